// File: rtl/mul_seq_pkg.sv
// Shared encodings and constants for the sequential RV32M multiplier.
package mul_seq_pkg;

    // Number of byte-pair partial products for a 32x32 multiply
    localparam int unsigned NPP = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/wallace.sv
// 8x8 unsigned combinational multiplier with a 16-bit product.
module wallace (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);

    // Plain product; the compression tree is left to synthesis
    always_comb begin
        o_p = 16'(i_a) * 16'(i_b);
    end

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU unit. One 8x8 multiplier is
// reused over 16 byte pairs of the operand magnitudes; signed results are
// recovered by negating the accumulated magnitude product.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e              r_state;
    state_e              w_state_d;
    op_e                 r_op;
    logic                r_neg;
    logic [XLEN-1:0]     r_ma;
    logic [XLEN-1:0]     r_mb;
    logic [XLEN-1:0]     r_result;
    logic [2*XLEN-1:0]   r_acc;
    logic [3:0]          r_k;

    op_e                 w_op;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_ma;
    logic [XLEN-1:0]     w_mb;
    logic [1:0]          w_i;
    logic [1:0]          w_j;
    logic [7:0]          w_a;
    logic [7:0]          w_b;
    logic [15:0]         w_pp;
    logic [5:0]          w_shamt;
    logic [2*XLEN-1:0]   w_pp_sh;
    logic [2*XLEN-1:0]   w_p;

    // Operand sign handling; MUL only needs the low half, so it stays unsigned
    assign w_op = op_e'(op);
    assign w_sa = src1[XLEN-1] & (w_op == OP_MULH || w_op == OP_MULHSU);
    assign w_sb = src2[XLEN-1] & (w_op == OP_MULH);
    assign w_ma = w_sa ? -src1 : src1;
    assign w_mb = w_sb ? -src2 : src2;

    // k[1:0] walks bytes of ma, k[3:2] walks bytes of mb
    assign w_i = r_k[1:0];
    assign w_j = r_k[3:2];
    assign w_a = r_ma[{w_i, 3'b000} +: 8];
    assign w_b = r_mb[{w_j, 3'b000} +: 8];

    wallace u_wallace (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_pp)
    );

    // Partial product weight is 2^(8*(i+j))
    assign w_shamt = {({1'b0, w_i} + {1'b0, w_j}), 3'b000};
    assign w_pp_sh = {{(2*XLEN-16){1'b0}}, w_pp} << w_shamt;
    assign w_p     = r_neg ? -r_acc : r_acc;

    assign result = r_result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_d = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_k == 4'(NPP - 1)) begin
                    w_state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                w_state_d = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Operand capture, accumulation and final sign fix-up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= w_op;
                        r_neg <= w_sa ^ w_sb;
                        r_ma  <= w_ma;
                        r_mb  <= w_mb;
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + w_pp_sh;
                    r_k   <= r_k + 4'd1;
                end
                S_FIX: begin
                    r_result <= (r_op == OP_MUL) ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end

endmodule
